// File: rtl/boot_ctrl_regs_if.sv
// Host register bus for the boot controller: one write port with byte
// enables and one read port with a registered read-data return.
interface boot_ctrl_regs_if;
    logic [15:0] WRADDR;
    logic [3:0]  BYTEEN;
    logic        WREN;
    logic [31:0] WDATA;
    logic [15:0] RDADDR;
    logic        RDEN;
    logic [31:0] RDATA;

    modport master (
        output WRADDR, BYTEEN, WREN, WDATA, RDADDR, RDEN,
        input  RDATA
    );

    modport slave (
        input  WRADDR, BYTEEN, WREN, WDATA, RDADDR, RDEN,
        output RDATA
    );
endinterface

// File: rtl/boot_ctrl_regs.sv
// BOOTCTRL register window: latches DRAM base / entry PC and sequences the
// CPU core through HOLD -> timed reset PULSE -> RUN.
module boot_ctrl_regs #(
    parameter logic [15:0] BASE_ADDR    = 16'h1000,
    parameter int unsigned RST_CYCLES   = 16,
    parameter logic [31:0] DRAMBASE_RST = 32'h0000_0000,
    parameter logic [31:0] ENTRYPC_RST  = 32'h0000_0000
) (
    input  logic              ACLK,
    input  logic              ARESET,
    boot_ctrl_regs_if.slave   bus,
    output logic              cpu_rst,
    output logic [31:0]       cpu_dram_base,
    output logic [31:0]       cpu_entry_pc,
    output logic              cpu_running
);

    localparam logic [15:0] ADDR_STATUS   = BASE_ADDR;
    localparam logic [15:0] ADDR_CTRL     = BASE_ADDR + 16'h0004;
    localparam logic [15:0] ADDR_DRAMBASE = BASE_ADDR + 16'h0008;
    localparam logic [15:0] ADDR_ENTRYPC  = BASE_ADDR + 16'h000C;
    localparam logic [15:0] CNT_LOAD      = 16'(RST_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_HOLD  = 2'd0,
        ST_PULSE = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        hold_q, hold_d;
    logic        cpu_rst_q, cpu_rst_d;
    logic        cpu_running_q, cpu_running_d;
    logic [7:0]  start_count_q, start_count_d;
    logic [31:0] dram_q, dram_d;
    logic [31:0] entry_q, entry_d;
    logic [31:0] cpu_dram_q, cpu_dram_d;
    logic [31:0] cpu_entry_q, cpu_entry_d;
    logic [31:0] rdata_q, rdata_d;

    logic        wr_ctrl, wr_dram, wr_entry;
    logic        hold_set, start_acc;
    logic [31:0] rd_val;
    logic [31:0] status_val;

    assign wr_ctrl  = bus.WREN && (bus.WRADDR == ADDR_CTRL);
    assign wr_dram  = bus.WREN && (bus.WRADDR == ADDR_DRAMBASE);
    assign wr_entry = bus.WREN && (bus.WRADDR == ADDR_ENTRYPC);

    // Byte-lane merge of the two address registers.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign dram_d[8*gi +: 8]  = (wr_dram && bus.BYTEEN[gi])
                                        ? bus.WDATA[8*gi +: 8] : dram_q[8*gi +: 8];
            assign entry_d[8*gi +: 8] = (wr_entry && bus.BYTEEN[gi])
                                        ? bus.WDATA[8*gi +: 8] : entry_q[8*gi +: 8];
        end
    endgenerate

    assign status_val = {16'h0000, start_count_q, 2'b00, state_q, 1'b0,
                         cpu_running_q, cpu_rst_q, hold_q};

    // A START is only honoured when the same write leaves HOLD_RESET at 0.
    always_comb begin
        hold_d    = hold_q;
        hold_set  = 1'b0;
        start_acc = 1'b0;
        if (wr_ctrl && bus.BYTEEN[0]) begin
            hold_d    = bus.WDATA[0];
            hold_set  = bus.WDATA[0];
            start_acc = bus.WDATA[1] & ~bus.WDATA[0];
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (hold_set) begin
            state_d = ST_HOLD;
            cnt_d   = 16'h0000;
        end else if (start_acc) begin
            state_d = ST_PULSE;
            cnt_d   = CNT_LOAD;
        end else begin
            case (state_q)
                ST_PULSE: begin
                    if (cnt_q == 16'h0000) begin
                        state_d = ST_RUN;
                    end else begin
                        cnt_d = cnt_q - 16'h0001;
                    end
                end
                ST_RUN:  state_d = ST_RUN;
                default: state_d = ST_HOLD;
            endcase
        end
        cpu_rst_d     = (state_d != ST_RUN);
        cpu_running_d = (state_d == ST_RUN);
    end

    // The core-facing copies only move on an accepted START, and take the
    // post-write register contents.
    always_comb begin
        start_count_d = start_acc ? start_count_q + 8'd1 : start_count_q;
        cpu_dram_d    = start_acc ? dram_d  : cpu_dram_q;
        cpu_entry_d   = start_acc ? entry_d : cpu_entry_q;
    end

    always_comb begin
        rd_val = 32'h0000_0000;
        case (bus.RDADDR)
            ADDR_STATUS:   rd_val = status_val;
            ADDR_CTRL:     rd_val = {31'h0, hold_q};
            ADDR_DRAMBASE: rd_val = dram_q;
            ADDR_ENTRYPC:  rd_val = entry_q;
            default:       rd_val = 32'h0000_0000;
        endcase
        rdata_d = bus.RDEN ? rd_val : rdata_q;
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q       <= ST_HOLD;
            cnt_q         <= 16'h0000;
            hold_q        <= 1'b1;
            cpu_rst_q     <= 1'b1;
            cpu_running_q <= 1'b0;
            start_count_q <= 8'h00;
            dram_q        <= DRAMBASE_RST;
            entry_q       <= ENTRYPC_RST;
            cpu_dram_q    <= DRAMBASE_RST;
            cpu_entry_q   <= ENTRYPC_RST;
            rdata_q       <= 32'h0000_0000;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            hold_q        <= hold_d;
            cpu_rst_q     <= cpu_rst_d;
            cpu_running_q <= cpu_running_d;
            start_count_q <= start_count_d;
            dram_q        <= dram_d;
            entry_q       <= entry_d;
            cpu_dram_q    <= cpu_dram_d;
            cpu_entry_q   <= cpu_entry_d;
            rdata_q       <= rdata_d;
        end
    end

    assign bus.RDATA     = rdata_q;
    assign cpu_rst       = cpu_rst_q;
    assign cpu_running   = cpu_running_q;
    assign cpu_dram_base = cpu_dram_q;
    assign cpu_entry_pc  = cpu_entry_q;

endmodule

// File: tb/tb_boot_ctrl_regs.sv
// Directed bench for boot_ctrl_regs: a cycle model of the register window
// is compared against the DUT every cycle, plus hand-computed spot checks.
module tb_boot_ctrl_regs;

    localparam logic [15:0] BASE    = 16'h1000;
    localparam logic [15:0] A_STAT  = BASE;
    localparam logic [15:0] A_CTRL  = BASE + 16'h4;
    localparam logic [15:0] A_DRAM  = BASE + 16'h8;
    localparam logic [15:0] A_ENTRY = BASE + 16'hC;
    localparam int          RSTC    = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cpu_rst;
    logic [31:0] cpu_dram_base;
    logic [31:0] cpu_entry_pc;
    logic        cpu_running;

    always #5 clk = ~clk;

    boot_ctrl_regs_if bus ();

    boot_ctrl_regs #(
        .BASE_ADDR   (BASE),
        .RST_CYCLES  (RSTC),
        .DRAMBASE_RST(32'h0000_0000),
        .ENTRYPC_RST (32'h0000_0000)
    ) dut (
        .ACLK         (clk),
        .ARESET       (rst),
        .bus          (bus),
        .cpu_rst      (cpu_rst),
        .cpu_dram_base(cpu_dram_base),
        .cpu_entry_pc (cpu_entry_pc),
        .cpu_running  (cpu_running)
    );

    int checks = 0;
    int errors = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: "pulse_left" is how many more cycles the core stays in reset
    // before it runs; in_hold means the core is parked until a START.
    typedef struct packed {
        logic        hold;
        logic        in_hold;
        logic [31:0] pulse_left;
        logic [31:0] dram;
        logic [31:0] entry;
        logic [31:0] cdram;
        logic [31:0] centry;
        logic [7:0]  sc;
        logic [31:0] rdata;
    } model_t;

    model_t m;

    function automatic logic [1:0] m_state(input model_t s);
        if (s.in_hold) return 2'd0;
        if (s.pulse_left != 0) return 2'd1;
        return 2'd2;
    endfunction

    function automatic logic [31:0] lanes(input logic [31:0] old, input logic [31:0] d, input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    function automatic logic [31:0] read_reg(input model_t s, input logic [15:0] a);
        logic [1:0] st;
        st = m_state(s);
        if (a == A_STAT)
            return {16'h0, s.sc, 2'b00, st, 1'b0, (st == 2'd2), (st != 2'd2), s.hold};
        if (a == A_CTRL)  return {31'h0, s.hold};
        if (a == A_DRAM)  return s.dram;
        if (a == A_ENTRY) return s.entry;
        return 32'h0;
    endfunction

    function automatic model_t reset_model();
        model_t r;
        r = '0;
        r.hold    = 1'b1;
        r.in_hold = 1'b1;
        return r;
    endfunction

    function automatic model_t step(input model_t s, input logic wren, input logic [15:0] wa,
                                    input logic [3:0] be, input logic [31:0] wd,
                                    input logic rden, input logic [15:0] ra);
        model_t n;
        n = s;
        if (rden) n.rdata = read_reg(s, ra);
        if (!s.in_hold && s.pulse_left != 0) n.pulse_left = s.pulse_left - 1;
        if (wren) begin
            if (wa == A_DRAM) n.dram = lanes(s.dram, wd, be);
            else if (wa == A_ENTRY) n.entry = lanes(s.entry, wd, be);
            else if (wa == A_CTRL && be[0]) begin
                n.hold = wd[0];
                if (wd[0]) begin
                    n.in_hold    = 1'b1;
                    n.pulse_left = 0;
                end else if (wd[1]) begin
                    n.in_hold    = 1'b0;
                    n.pulse_left = RSTC;
                    n.sc         = s.sc + 8'd1;
                    n.cdram      = n.dram;
                    n.centry     = n.entry;
                end
            end
        end
        return n;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) m <= reset_model();
        else m <= step(m, bus.WREN, bus.WRADDR, bus.BYTEEN, bus.WDATA, bus.RDEN, bus.RDADDR);
    end

    logic check_en = 1'b0;

    always @(negedge clk) begin
        if (check_en) begin
            check32("rdata",       bus.RDATA,            m.rdata);
            check32("cpu_rst",     {31'h0, cpu_rst},     {31'h0, m_state(m) != 2'd2});
            check32("cpu_running", {31'h0, cpu_running}, {31'h0, m_state(m) == 2'd2});
            check32("cpu_dram",    cpu_dram_base,        m.cdram);
            check32("cpu_entry",   cpu_entry_pc,         m.centry);
        end
    end

    task automatic wr(input logic [15:0] a, input logic [3:0] be, input logic [31:0] d);
        bus.WREN = 1'b1; bus.WRADDR = a; bus.BYTEEN = be; bus.WDATA = d;
        @(negedge clk);
        bus.WREN = 1'b0;
        $display("WR  addr=%h be=%h data=%h", a, be, d);
    endtask

    task automatic rd(input logic [15:0] a, output logic [31:0] d);
        bus.RDEN = 1'b1; bus.RDADDR = a;
        @(negedge clk);
        bus.RDEN = 1'b0;
        d = bus.RDATA;
        $display("RD  addr=%h data=%h", a, d);
    endtask

    task automatic wrrd(input logic [15:0] a, input logic [31:0] wd, output logic [31:0] d);
        bus.WREN = 1'b1; bus.WRADDR = a; bus.BYTEEN = 4'hF; bus.WDATA = wd;
        bus.RDEN = 1'b1; bus.RDADDR = a;
        @(negedge clk);
        bus.WREN = 1'b0; bus.RDEN = 1'b0;
        d = bus.RDATA;
        $display("WRD addr=%h wdata=%h rdata=%h", a, wd, d);
    endtask

    task automatic pulse_len(output int n);
        n = 0;
        while (cpu_rst && n < 100) begin
            n++;
            @(negedge clk);
        end
        $display("PULSE cycles=%0d", n);
    endtask

    logic [31:0] v;
    int          n;

    initial begin
        bus.WREN = 1'b0; bus.WRADDR = '0; bus.BYTEEN = '0; bus.WDATA = '0;
        bus.RDEN = 1'b0; bus.RDADDR = '0;
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        check32("rst_rdata", bus.RDATA, 32'h0);
        check32("rst_cpu_rst", {31'h0, cpu_rst}, 32'h1);
        rst = 1'b0;
        check_en = 1'b1;

        rd(A_STAT, v);                 check32("status_reset", v, 32'h0000_0003);
        check32("dram_reset", cpu_dram_base, 32'h0);

        wr(A_DRAM, 4'hF, 32'h2000_0000);
        wr(A_ENTRY, 4'hF, 32'h0000_0000);
        wr(A_CTRL, 4'h1, 32'h2);
        pulse_len(n);                  check32("pulse1_len", n, RSTC);
        rd(A_STAT, v);                 check32("status_run1", v, 32'h0000_0124);
        check32("cpu_dram1", cpu_dram_base, 32'h2000_0000);

        wr(A_DRAM, 4'hF, 32'h3000_0000);
        check32("dram_stable", cpu_dram_base, 32'h2000_0000);
        wr(A_CTRL, 4'h1, 32'h2);
        pulse_len(n);                  check32("pulse2_len", n, RSTC);
        check32("cpu_dram2", cpu_dram_base, 32'h3000_0000);
        rd(A_STAT, v);                 check32("status_run2", v, 32'h0000_0224);

        wr(A_CTRL, 4'h1, 32'h1);
        check32("hold_rst", {31'h0, cpu_rst}, 32'h1);
        rd(A_STAT, v);                 check32("status_hold", v, 32'h0000_0203);
        wr(A_CTRL, 4'h1, 32'h3);
        repeat (3) @(negedge clk);
        rd(A_STAT, v);                 check32("hold_wins", v, 32'h0000_0203);
        wr(A_CTRL, 4'hE, 32'h2);
        rd(A_STAT, v);                 check32("ctrl_lane0_off", v, 32'h0000_0203);
        wr(A_CTRL, 4'h1, 32'h0);
        rd(A_STAT, v);                 check32("hold_cleared", v, 32'h0000_0202);
        wr(A_CTRL, 4'h1, 32'h2);
        rd(A_STAT, v);                 check32("start_after_clear", v, 32'h0000_0312);
        repeat (20) @(negedge clk);

        wr(A_DRAM, 4'hF, 32'h0);
        wr(A_DRAM, 4'b0100, 32'hAABB_CCDD);
        rd(A_DRAM, v);                 check32("byte_lane", v, 32'h00BB_0000);
        rd(16'h1010, v);               check32("unmapped_1010", v, 32'h0);
        rd(16'h1002, v);               check32("unaligned_1002", v, 32'h0);
        wr(16'h1010, 4'hF, 32'hFFFF_FFFF);
        wr(16'h1009, 4'hF, 32'hFFFF_FFFF);
        rd(A_DRAM, v);                 check32("no_alias_dram", v, 32'h00BB_0000);
        rd(A_ENTRY, v);                check32("no_alias_entry", v, 32'h0);
        wrrd(A_DRAM, 32'h1234_5678, v); check32("rd_before_wr", v, 32'h00BB_0000);
        rd(A_DRAM, v);                 check32("rd_after_wr", v, 32'h1234_5678);

        wr(A_DRAM, 4'hF, 32'h4000_0000);
        wr(A_CTRL, 4'h1, 32'h2);
        rd(A_DRAM, v);
        repeat (4) @(negedge clk);
        check32("pre_arst_dram", cpu_dram_base, 32'h4000_0000);
        #2 rst = 1'b1;
        #1;
        check32("arst_dram", cpu_dram_base, 32'h0);
        check32("arst_rdata", bus.RDATA, 32'h0);
        check32("arst_rst", {31'h0, cpu_rst}, 32'h1);
        @(negedge clk) rst = 1'b0;
        rd(A_STAT, v);                 check32("status_after_arst", v, 32'h0000_0003);
        rd(A_DRAM, v);                 check32("dram_after_arst", v, 32'h0);

        wr(A_CTRL, 4'h1, 32'h2);
        pulse_len(n);
        check32("run_before_arst", {31'h0, cpu_running}, 32'h1);
        #2 rst = 1'b1;
        #1;
        check32("arst_run_rst", {31'h0, cpu_rst}, 32'h1);
        check32("arst_run_running", {31'h0, cpu_running}, 32'h0);
        @(negedge clk) rst = 1'b0;

        for (int i = 0; i < 255; i++) wr(A_CTRL, 4'h1, 32'h2);
        rd(A_STAT, v);                 check32("count_255", v, 32'h0000_FF12);
        wr(A_CTRL, 4'h1, 32'h2);
        rd(A_STAT, v);                 check32("count_wrap", v, 32'h0000_0012);
        repeat (20) @(negedge clk);

        check_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
